moldudp64_hdr_parser: RTL
=========================

// Module: moldudp64_hdr_parser
// PURPOSE
//  Streaming parser for Ethernet/IPv4/UDP/MoldUDP64 frames, parametrised in bus width.
//  Optional 802.1Q VLAN tag. Filters on UDP destination port.
//  Latches the header fields and forwards the MoldUDP64 payload (ITCH messages) downstream.
//  Sits between the MAC rx stream and the ITCH message decoder.
// PARAMETERS
//  DATA_W         64      bus width in bits; one of 32/64/128; byte 0 of a beat is s_data[DATA_W-1 -: 8]
//  DEST_PORT      16'd0   UDP dest port accepted when PORT_FILTER_EN=1
//  PORT_FILTER_EN 1'b0    1: drop frames whose UDP dst port != DEST_PORT
//  CNT_W          16      width of drop_cnt (saturating)
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            asynchronous, active-low reset
//  s_data        in   DATA_W       rx frame data, network byte order
//  s_keep        in   DATA_W/8     byte enables, MSB = byte 0; all-ones except on the s_last beat
//  s_valid       in   1            input beat valid
//  s_last        in   1            last beat of frame
//  s_ready       out  1            input beat accepted when s_valid && s_ready
//  m_data        out  DATA_W       payload data, same lane positions as input (not realigned)
//  m_keep        out  DATA_W/8     payload byte enables
//  m_valid       out  1            payload beat valid
//  m_last        out  1            last payload beat
//  m_ready       in   1            downstream accept
//  hdr_valid     out  1            1-cycle pulse: fields below updated, frame accepted
//  vlan_present  out  1            frame carried 0x8100 tag
//  src_ip        out  32           IPv4 source
//  dst_ip        out  32           IPv4 destination
//  src_port      out  16           UDP source port
//  dst_port      out  16           UDP destination port
//  session_id    out  80           MoldUDP64 session
//  seq_num       out  64           MoldUDP64 sequence number
//  msg_count     out  16           MoldUDP64 message count
//  hdr_drop      out  1            1-cycle pulse: frame rejected
//  drop_cnt      out  CNT_W        saturating count of rejected frames
//  beat_cnt      out  7            accepted-beat index within current frame, saturates at 127
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE. All outputs 0, including drop_cnt and the field registers.
//   The first accepted beat after reset is treated as start of frame.
//  States: IDLE -> HDR on first beat -> PAY when the last header byte is accepted -> IDLE after s_last.
//   Any state -> DROP on a reject condition; DROP -> IDLE after s_last.
//  Header length HL = 62 bytes, or 66 if bytes 12..13 == 0x8100.
//   With VLAN, EtherType is read at bytes 16..17; offsets of all later fields shift by 4.
//   Header bytes are shifted into an HL-byte buffer and the fields are extracted from it.
//  Reject conditions:
//   EtherType != 0x0800
//   IPv4 version/IHL byte != 0x45
//   IP protocol != 17
//   port mismatch (only when PORT_FILTER_EN=1)
//   s_last before byte HL-1 (runt frame)
//  On reject: hdr_drop pulses once; drop_cnt++ (saturates at all-ones); the rest of the frame is discarded with s_ready=1.
//  hdr_valid pulses in the cycle after the beat holding header byte HL-1 is accepted; the fields are valid from that cycle.
//   hdr_valid and hdr_drop are never both asserted for the same frame.
//  Fields keep their value until the next hdr_valid; a dropped frame does not change them.
//  s_ready = 1 in IDLE, HDR and DROP. In PAY: s_ready = !m_valid || m_ready (single register stage).
//  Payload: in the beat containing byte HL-1, m_keep holds only the lanes after the header lanes.
//   If that beat carries no payload bytes, it is not emitted.
//   Later beats are passed through with s_keep.
//   m_last marks the frame's s_last beat; a frame with no payload emits no m_valid.
//  m_data, m_keep and m_last hold while m_valid && !m_ready.
//  beat_cnt resets to 0 at each start of frame.
// TESTING
//  DATA_W=64, untagged 70-byte frame, dst port 26400, filter off -> hdr_valid on the cycle after beat 7.
//   Beat 7 payload has m_keep=8'h03; beat 8 has m_keep=s_keep and m_last=1; seq_num and msg_count match the stimulus.
//  Same frame with VLAN tag 0x8100 (74 bytes) -> vlan_present=1; header ends in beat 8 with m_keep=8'h3F; fields identical.
//  PORT_FILTER_EN=1, DEST_PORT=26400, frame with dst port 26401 -> hdr_drop=1, drop_cnt 0->1, no m_valid, no hdr_valid.
//  Runt 48-byte frame (s_last on beat 5) -> hdr_drop=1; the next good frame parses normally.
//  m_ready held 0 for 5 cycles mid-payload -> s_ready=0 and m_data stable; no beat lost or duplicated after release.
//  rst pulsed low mid-payload -> all outputs 0 immediately; the next good frame parses and drop_cnt=0.

Source files
------------

// File: rtl/moldudp64_hdr_parser.sv
// MoldUDP64 header parser: Ethernet (optional 802.1Q) / IPv4 / UDP / MoldUDP64.
// Header bytes are collected into a byte buffer, and the fields are decoded from it.
// Good frames latch the header fields and forward the payload lanes.
// Bad or runt frames are counted and discarded.
module moldudp64_hdr_parser #(
  parameter int          DATA_W         = 64,
  parameter logic [15:0] DEST_PORT      = 16'd0,
  parameter bit          PORT_FILTER_EN = 1'b0,
  parameter int          CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                hdr_valid,
  output logic                vlan_present,
  output logic [31:0]         src_ip,
  output logic [31:0]         dst_ip,
  output logic [15:0]         src_port,
  output logic [15:0]         dst_port,
  output logic [79:0]         session_id,
  output logic [63:0]         seq_num,
  output logic [15:0]         msg_count,
  output logic                hdr_drop,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [6:0]          beat_cnt
);

  localparam int BYTES   = DATA_W / 8;
  localparam int HDR_MAX = 66;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

  state_t              state_q;
  logic [7:0]          byteOff_q;
  logic [7:0]          hdrBuf_q [HDR_MAX];
  logic [7:0]          hdrBuf_d [HDR_MAX];
  logic [DATA_W-1:0]   mData_q;
  logic [BYTES-1:0]    mKeep_q;
  logic                mValid_q, mLast_q;
  logic                hdrValid_q, hdrDrop_q, vlanPresent_q;
  logic [31:0]         srcIp_q, dstIp_q;
  logic [15:0]         srcPort_q, dstPort_q, msgCount_q;
  logic [79:0]         sessionId_q;
  logic [63:0]         seqNum_q;
  logic [CNT_W-1:0]    dropCnt_q;
  logic [6:0]          beatCnt_q;

  logic                acceptBeat;
  int                  offEff, nValid, endByte, hl;
  logic [6:0]          vo;
  logic                vlanHit, hdrDone, frameBad;
  logic [15:0]         etherType, curSrcPort, curDstPort, curMsgCount;
  logic [7:0]          verIhl, ipProto;
  logic [31:0]         curSrcIp, curDstIp;
  logic [79:0]         curSession;
  logic [63:0]         curSeq;
  logic [BYTES-1:0]    payKeep;

  // Input is always accepted except while the payload register is stalled.
  always_comb begin
    s_ready    = (state_q == PAY) ? (!mValid_q || m_ready) : 1'b1;
    acceptBeat = s_valid && s_ready;
  end

  // Merge the current beat into the header buffer and decode fields from the merged view.
  always_comb begin
    offEff   = (state_q == IDLE) ? 0 : int'(byteOff_q);
    nValid   = s_last ? $countones(s_keep) : BYTES;
    endByte  = offEff + nValid;
    hdrBuf_d = hdrBuf_q;
    for (int i = 0; i < BYTES; i++) begin
      if (i < nValid && offEff + i < HDR_MAX) begin
        hdrBuf_d[7'(offEff + i)] = s_data[8*(BYTES-1-i) +: 8];
      end
    end
    vlanHit   = ({hdrBuf_d[12], hdrBuf_d[13]} == 16'h8100);
    vo        = vlanHit ? 7'd4 : 7'd0;
    hl        = vlanHit ? 66 : 62;
    hdrDone   = (endByte >= hl);
    etherType = {hdrBuf_d[7'd12 + vo], hdrBuf_d[7'd13 + vo]};
    verIhl    = hdrBuf_d[7'd14 + vo];
    ipProto   = hdrBuf_d[7'd23 + vo];
    curSrcIp  = '0;
    curDstIp  = '0;
    for (int i = 0; i < 4; i++) begin
      curSrcIp[8*(3-i) +: 8] = hdrBuf_d[7'd26 + vo + 7'(i)];
      curDstIp[8*(3-i) +: 8] = hdrBuf_d[7'd30 + vo + 7'(i)];
    end
    curSrcPort  = {hdrBuf_d[7'd34 + vo], hdrBuf_d[7'd35 + vo]};
    curDstPort  = {hdrBuf_d[7'd36 + vo], hdrBuf_d[7'd37 + vo]};
    curSession  = '0;
    for (int i = 0; i < 10; i++) begin
      curSession[8*(9-i) +: 8] = hdrBuf_d[7'd42 + vo + 7'(i)];
    end
    curSeq = '0;
    for (int i = 0; i < 8; i++) begin
      curSeq[8*(7-i) +: 8] = hdrBuf_d[7'd52 + vo + 7'(i)];
    end
    curMsgCount = {hdrBuf_d[7'd60 + vo], hdrBuf_d[7'd61 + vo]};
    frameBad = (etherType != 16'h0800) || (verIhl != 8'h45) || (ipProto != 8'd17) ||
               (PORT_FILTER_EN && (curDstPort != DEST_PORT));
    payKeep = '0;
    for (int i = 0; i < BYTES; i++) begin
      payKeep[BYTES-1-i] = s_keep[BYTES-1-i] && (offEff + i >= hl);
    end
  end

  // Frame FSM with registered header fields, drop accounting and payload output stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      byteOff_q     <= '0;
      for (int k = 0; k < HDR_MAX; k++) hdrBuf_q[k] <= '0;
      mData_q       <= '0;
      mKeep_q       <= '0;
      mValid_q      <= 1'b0;
      mLast_q       <= 1'b0;
      hdrValid_q    <= 1'b0;
      hdrDrop_q     <= 1'b0;
      vlanPresent_q <= 1'b0;
      srcIp_q       <= '0;
      dstIp_q       <= '0;
      srcPort_q     <= '0;
      dstPort_q     <= '0;
      sessionId_q   <= '0;
      seqNum_q      <= '0;
      msgCount_q    <= '0;
      dropCnt_q     <= '0;
      beatCnt_q     <= '0;
    end else begin
      hdrValid_q <= 1'b0;
      hdrDrop_q  <= 1'b0;
      if (m_ready) mValid_q <= 1'b0;
      if (acceptBeat) begin
        if (state_q == IDLE) beatCnt_q <= '0;
        else if (beatCnt_q != 7'h7f) beatCnt_q <= beatCnt_q + 7'd1;
        case (state_q)
          IDLE, HDR: begin
            hdrBuf_q  <= hdrBuf_d;
            byteOff_q <= 8'(endByte);
            if (hdrDone && !frameBad) begin
              hdrValid_q    <= 1'b1;
              vlanPresent_q <= vlanHit;
              srcIp_q       <= curSrcIp;
              dstIp_q       <= curDstIp;
              srcPort_q     <= curSrcPort;
              dstPort_q     <= curDstPort;
              sessionId_q   <= curSession;
              seqNum_q      <= curSeq;
              msgCount_q    <= curMsgCount;
              state_q       <= s_last ? IDLE : PAY;
              if (|payKeep) begin
                mValid_q <= 1'b1;
                mData_q  <= s_data;
                mKeep_q  <= payKeep;
                mLast_q  <= s_last;
              end
            end else if (hdrDone || s_last) begin
              hdrDrop_q <= 1'b1;
              if (dropCnt_q != '1) dropCnt_q <= dropCnt_q + 1'b1;
              state_q   <= s_last ? IDLE : DROP;
            end else begin
              state_q <= HDR;
            end
          end
          PAY: begin
            mValid_q <= 1'b1;
            mData_q  <= s_data;
            mKeep_q  <= s_keep;
            mLast_q  <= s_last;
            if (s_last) state_q <= IDLE;
          end
          DROP: begin
            if (s_last) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_data       = mData_q;
  assign m_keep       = mKeep_q;
  assign m_valid      = mValid_q;
  assign m_last       = mLast_q;
  assign hdr_valid    = hdrValid_q;
  assign hdr_drop     = hdrDrop_q;
  assign vlan_present = vlanPresent_q;
  assign src_ip       = srcIp_q;
  assign dst_ip       = dstIp_q;
  assign src_port     = srcPort_q;
  assign dst_port     = dstPort_q;
  assign session_id   = sessionId_q;
  assign seq_num      = seqNum_q;
  assign msg_count    = msgCount_q;
  assign drop_cnt     = dropCnt_q;
  assign beat_cnt     = beatCnt_q;

endmodule
